// File: rtl/flash_ctrl_param.sv
// Parallel NOR flash controller: word reads and single-location programming with
// internally generated bus timing, STS polling with timeout, and a split data bus.
module flash_ctrl_param #(
   parameter int          AW      = 24,
   parameter int          DW      = 8,
   parameter int          T_ACC   = 5,
   parameter int          T_WP    = 4,
   parameter logic [19:0] TIMEOUT = 20'd500000
) (
   input  logic          CLK_50MHZ,
   input  logic          RST,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] data,
   input  logic          direction_rw,
   input  logic          fb_action,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          NF_CE,
   output logic          NF_OE,
   output logic          NF_WE,
   output logic          NF_RP,
   output logic          NF_WP,
   output logic          NF_BYTE,
   input  logic          NF_STS,
   output logic [AW-1:0] NF_A,
   output logic [DW-1:0] NF_D_OUT,
   input  logic [DW-1:0] NF_D_IN,
   output logic          NF_D_OE,
   output logic [3:0]    dbg_state
);

   // Handshake: fb_action is a single-clock request, accepted only when the FSM is
   // idle and the reset-recovery count has expired; busy rises the next clock and
   // falls the clock after the one-clock done pulse. Requests at other times are dropped.

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_SETUP,
      S_RD_WAIT,
      S_RD_END,
      S_WR_SETUP,
      S_WR_PULSE,
      S_WR_HOLD,
      S_POLL,
      S_PG_END
   } state_t;

   typedef enum logic [1:0] {
      PH_CMD_SETUP,
      PH_CMD_DATA,
      PH_READARRAY
   } phase_t;

   localparam int TMAX = (T_ACC > T_WP) ? T_ACC : T_WP;
   localparam int TCW  = $clog2(TMAX + 1);

   localparam logic [DW-1:0] CMD_PROGRAM    = DW'(8'h40);
   localparam logic [DW-1:0] CMD_READ_ARRAY = DW'(8'hFF);

   // NF_RP rises on the first clock; the following 4 clocks are recovery time.
   localparam logic [2:0] RP_RECOVERY = 3'd5;

   state_t          state;
   phase_t          phase;
   logic [TCW-1:0]  tcnt;
   logic [19:0]     poll_cnt;
   logic [2:0]      rec_cnt;
   logic [DW-1:0]   lat_data;

   assign NF_WP     = 1'b1;
   assign NF_BYTE   = (DW == 16);
   assign dbg_state = state;

   always_ff @(posedge CLK_50MHZ or negedge RST) begin
      if (!RST) begin
         state    <= S_IDLE;
         phase    <= PH_CMD_SETUP;
         tcnt     <= '0;
         poll_cnt <= '0;
         rec_cnt  <= RP_RECOVERY;
         lat_data <= '0;
         rdata    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         NF_CE    <= 1'b1;
         NF_OE    <= 1'b1;
         NF_WE    <= 1'b1;
         NF_RP    <= 1'b0;
         NF_A     <= '0;
         NF_D_OUT <= '0;
         NF_D_OE  <= 1'b0;
      end else begin
         NF_RP <= 1'b1;
         done  <= 1'b0;
         if (rec_cnt != 3'd0) rec_cnt <= rec_cnt - 3'd1;

         case (state)
            S_IDLE: begin
               if (fb_action && rec_cnt == 3'd0) begin
                  lat_data <= data;
                  err      <= 1'b0;
                  busy     <= 1'b1;
                  NF_A     <= addr;
                  NF_CE    <= 1'b0;
                  if (direction_rw) begin
                     phase    <= PH_CMD_SETUP;
                     NF_D_OUT <= CMD_PROGRAM;
                     NF_D_OE  <= 1'b1;
                     state    <= S_WR_SETUP;
                  end else begin
                     state <= S_RD_SETUP;
                  end
               end
            end

            S_RD_SETUP: begin
               NF_OE <= 1'b0;
               tcnt  <= TCW'(T_ACC - 1);
               state <= S_RD_WAIT;
            end

            S_RD_WAIT: begin
               if (tcnt == '0) begin
                  rdata <= NF_D_IN;
                  NF_OE <= 1'b1;
                  NF_CE <= 1'b1;
                  done  <= 1'b1;
                  state <= S_RD_END;
               end else begin
                  tcnt <= tcnt - TCW'(1);
               end
            end

            S_RD_END: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            S_WR_SETUP: begin
               NF_WE <= 1'b0;
               tcnt  <= TCW'(T_WP - 1);
               state <= S_WR_PULSE;
            end

            S_WR_PULSE: begin
               if (tcnt == '0) begin
                  NF_WE <= 1'b1;
                  NF_CE <= 1'b1;
                  state <= S_WR_HOLD;
               end else begin
                  tcnt <= tcnt - TCW'(1);
               end
            end

            // Data stays driven through the hold clock, then the bus is released
            // unless another write cycle follows immediately.
            S_WR_HOLD: begin
               NF_D_OE <= 1'b0;
               case (phase)
                  PH_CMD_SETUP: begin
                     phase    <= PH_CMD_DATA;
                     NF_D_OUT <= lat_data;
                     NF_D_OE  <= 1'b1;
                     NF_CE    <= 1'b0;
                     state    <= S_WR_SETUP;
                  end
                  PH_CMD_DATA: begin
                     poll_cnt <= '0;
                     state    <= S_POLL;
                  end
                  default: begin
                     done  <= 1'b1;
                     state <= S_PG_END;
                  end
               endcase
            end

            // The first two poll clocks ignore STS while the device asserts busy.
            S_POLL: begin
               if ((poll_cnt >= 20'd2) && NF_STS) begin
                  phase    <= PH_READARRAY;
                  NF_D_OUT <= CMD_READ_ARRAY;
                  NF_D_OE  <= 1'b1;
                  NF_CE    <= 1'b0;
                  state    <= S_WR_SETUP;
               end else if (poll_cnt == TIMEOUT - 20'd1) begin
                  err      <= 1'b1;
                  phase    <= PH_READARRAY;
                  NF_D_OUT <= CMD_READ_ARRAY;
                  NF_D_OE  <= 1'b1;
                  NF_CE    <= 1'b0;
                  state    <= S_WR_SETUP;
               end else begin
                  poll_cnt <= poll_cnt + 20'd1;
               end
            end

            S_PG_END: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_ctrl_param.sv
// Bench for flash_ctrl_param: flash array and STS behaviour modelled in the bench,
// directed scenarios followed by randomized read/program traffic.
module tb_flash_ctrl_param;

   localparam int          AW    = 24;
   localparam int          DW    = 8;
   localparam int          T_ACC = 5;
   localparam int          T_WP  = 4;
   localparam logic [19:0] TMO   = 20'd64;

   // clock / reset
   logic clk = 1'b0;
   logic RST = 1'b0;
   always #10 clk = ~clk;

   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          direction_rw, fb_action;
   logic [DW-1:0] rdata;
   logic          busy, done, err;
   logic          NF_CE, NF_OE, NF_WE, NF_RP, NF_WP, NF_BYTE, NF_STS;
   logic [AW-1:0] NF_A;
   logic [DW-1:0] NF_D_OUT, NF_D_IN;
   logic          NF_D_OE;
   logic [3:0]    dbg_state;

   logic [AW-1:0] addr16, a16;
   logic [15:0]   data16, rdata16, dout16, din16;
   logic          rw16, fb16, busy16, done16, err16;
   logic          ce16, oe16, we16, rp16, wp16, byte16, sts16, doe16;
   logic [3:0]    dbg16;

   flash_ctrl_param #(.AW(AW), .DW(DW), .T_ACC(T_ACC), .T_WP(T_WP), .TIMEOUT(TMO)) u_dut (
      .CLK_50MHZ(clk), .RST(RST), .addr(addr), .data(data), .direction_rw(direction_rw),
      .fb_action(fb_action), .rdata(rdata), .busy(busy), .done(done), .err(err),
      .NF_CE(NF_CE), .NF_OE(NF_OE), .NF_WE(NF_WE), .NF_RP(NF_RP), .NF_WP(NF_WP),
      .NF_BYTE(NF_BYTE), .NF_STS(NF_STS), .NF_A(NF_A), .NF_D_OUT(NF_D_OUT),
      .NF_D_IN(NF_D_IN), .NF_D_OE(NF_D_OE), .dbg_state(dbg_state)
   );

   flash_ctrl_param #(.AW(AW), .DW(16), .T_ACC(T_ACC), .T_WP(T_WP), .TIMEOUT(TMO)) u_dut16 (
      .CLK_50MHZ(clk), .RST(RST), .addr(addr16), .data(data16), .direction_rw(rw16),
      .fb_action(fb16), .rdata(rdata16), .busy(busy16), .done(done16), .err(err16),
      .NF_CE(ce16), .NF_OE(oe16), .NF_WE(we16), .NF_RP(rp16), .NF_WP(wp16),
      .NF_BYTE(byte16), .NF_STS(sts16), .NF_A(a16), .NF_D_OUT(dout16),
      .NF_D_IN(din16), .NF_D_OE(doe16), .dbg_state(dbg16)
   );

   // scoreboard state
   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] mem [int];
   logic [7:0] exp_last_rdata = 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] mem_rd(input logic [23:0] a);
      return mem.exists(int'(a)) ? mem[int'(a)] : 8'hFF;
   endfunction

   // Drives one host operation and plays the flash: array contents on reads,
   // STS low for 'low' clocks after the data write (or stuck low).
   task automatic run_op(input logic rw, input logic [23:0] a, input logic [7:0] d,
                         input int low, input logic stuck, input int inject);
      logic [7:0]  exp_q[$];
      logic [23:0] cap_a[$];
      logic [7:0]  cap_d[$];
      int          cap_w[$];
      int          n, done_cnt, done_n, oe_low, we_cnt, viol, sts_cnt, poll, exp_n;
      logic        prev_we, exp_err;
      logic [7:0]  exp_rd;
      n = 0; done_cnt = 0; done_n = 0; oe_low = 0; we_cnt = 0; viol = 0; sts_cnt = 0;
      prev_we = 1'b1; exp_rd = mem_rd(a); exp_err = 1'b0;
      poll = (low > 3) ? low : 3;
      if (stuck || poll > int'(TMO)) begin
         poll = int'(TMO);
         exp_err = 1'b1;
      end
      if (rw) begin
         exp_n = 3 * (T_WP + 2) + poll + 1;
         exp_q.push_back(8'h40);
         exp_q.push_back(d);
         exp_q.push_back(8'hFF);
      end else begin
         exp_n = T_ACC + 2;
         exp_err = 1'b0;
      end

      @(negedge clk);
      addr = a; data = d; direction_rw = rw; fb_action = 1'b1;
      while (n < 3000) begin
         @(negedge clk);
         n++;
         fb_action = (n == inject);
         if (n == inject) begin
            addr = ~a; data = ~d; direction_rw = ~rw;
         end
         if (n == 1) begin
            check_eq("busy_after_accept", 32'(busy), 32'd1);
            check_eq("err_cleared_on_accept", 32'(err), 32'd0);
         end
         if (NF_D_OE && !NF_OE) viol++;
         if (!NF_CE && !NF_OE && !NF_WE) viol++;
         if (!rw && NF_D_OE) viol++;
         if (!NF_OE) oe_low++;
         if (!NF_WE) we_cnt++;
         else if (!prev_we) begin
            cap_a.push_back(NF_A);
            cap_d.push_back(NF_D_OUT);
            cap_w.push_back(we_cnt);
            we_cnt = 0;
         end
         if (NF_WE && !prev_we && cap_d.size() == 2) sts_cnt = low;
         else if (sts_cnt > 0) sts_cnt--;
         prev_we = NF_WE;
         NF_STS  = !stuck && (sts_cnt == 0);
         NF_D_IN = !NF_OE ? mem_rd(NF_A) : 8'($urandom);
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) done_n = n;
         end
         if (done_cnt > 0 && n > done_n) break;
      end
      fb_action = 1'b0;

      check_eq("done_count", 32'(done_cnt), 32'd1);
      check_eq("done_latency", 32'(done_n), 32'(exp_n));
      check_eq("busy_after_done", 32'(busy), 32'd0);
      check_eq("err", 32'(err), 32'(exp_err));
      check_eq("bus_violations", 32'(viol), 32'd0);
      if (!rw) begin
         exp_last_rdata = exp_rd;
         check_eq("rdata", 32'(rdata), 32'(exp_rd));
         check_eq("oe_low_clocks", 32'(oe_low), 32'(T_ACC));
         check_eq("read_write_cycles", 32'(cap_d.size()), 32'd0);
      end else begin
         check_eq("rdata_kept", 32'(rdata), 32'(exp_last_rdata));
         check_eq("write_cycles", 32'(cap_d.size()), 32'(exp_q.size()));
         for (int i = 0; i < cap_d.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("wr%0d_addr", i), 32'(cap_a[i]), 32'(a));
            check_eq($sformatf("wr%0d_data", i), 32'(cap_d[i]), 32'(exp_q[i]));
            check_eq($sformatf("wr%0d_we_width", i), 32'(cap_w[i]), 32'(T_WP));
         end
         mem[int'(a)] = mem_rd(a) & d;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn, n16, cap16_n;
      logic [15:0] cap16[3];
      logic prev16;
      logic [23:0] ra;
      fb_action = 1'b0; addr = '0; data = '0; direction_rw = 1'b0;
      NF_STS = 1'b1; NF_D_IN = '0;
      fb16 = 1'b0; addr16 = '0; data16 = '0; rw16 = 1'b0; sts16 = 1'b1; din16 = '0;
      mem[32'h35] = 8'hC9;

      // reset values and recovery window
      repeat (3) @(negedge clk);
      check_eq("rst_ce", 32'(NF_CE), 32'd1);
      check_eq("rst_oe", 32'(NF_OE), 32'd1);
      check_eq("rst_we", 32'(NF_WE), 32'd1);
      check_eq("rst_rp", 32'(NF_RP), 32'd0);
      check_eq("rst_doe", 32'(NF_D_OE), 32'd0);
      check_eq("rst_a", 32'(NF_A), 32'd0);
      check_eq("rst_dout", 32'(NF_D_OUT), 32'd0);
      check_eq("rst_rdata", 32'(rdata), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("wp_high", 32'(NF_WP), 32'd1);
      check_eq("byte_dw8", 32'(NF_BYTE), 32'd0);
      RST = 1'b1;
      #1 check_eq("rp_before_clock", 32'(NF_RP), 32'd0);
      @(negedge clk);
      check_eq("rp_after_release", 32'(NF_RP), 32'd1);
      addr = 24'h35; direction_rw = 1'b0; fb_action = 1'b1;
      @(negedge clk);
      fb_action = 1'b0;
      check_eq("early_action_ignored", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      check_eq("still_idle", 32'(busy), 32'd0);

      // accepted at release+6, then directed reads/programs
      run_op(1'b0, 24'h35, 8'h00, 0, 1'b0, -1);
      run_op(1'b1, 24'h35, 8'hC9, 30, 1'b0, -1);
      run_op(1'b1, 24'h35, 8'h0F, 0, 1'b1, -1);
      repeat (3) @(negedge clk);
      check_eq("err_held_idle", 32'(err), 32'd1);
      run_op(1'b0, 24'h35, 8'h00, 0, 1'b0, -1);
      run_op(1'b1, 24'h100, 8'h3C, 10, 1'b0, 5);
      run_op(1'b0, 24'h100, 8'h00, 0, 1'b0, 3);

      // randomized traffic
      for (int k = 0; k < 16; k++) begin
         case ($urandom_range(0, 2))
            0: ra = 24'h35;
            1: ra = 24'h100;
            default: ra = 24'($urandom);
         endcase
         run_op(1'($urandom_range(0, 1)), ra, 8'($urandom), int'($urandom_range(0, 50)),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : -1);
      end

      // reset during the first write pulse
      @(negedge clk);
      addr = 24'h35; data = 8'h5A; direction_rw = 1'b1; fb_action = 1'b1;
      @(negedge clk);
      fb_action = 1'b0;
      @(negedge clk);
      check_eq("we_low_before_abort", 32'(NF_WE), 32'd0);
      #3 RST = 1'b0;
      #1;
      check_eq("abort_we", 32'(NF_WE), 32'd1);
      check_eq("abort_ce", 32'(NF_CE), 32'd1);
      check_eq("abort_doe", 32'(NF_D_OE), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_rp", 32'(NF_RP), 32'd0);
      @(negedge clk);
      RST = 1'b1;
      dn = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || busy) dn++;
      end
      check_eq("no_done_after_abort", 32'(dn), 32'd0);
      check_eq("rdata_reset_by_abort", 32'(rdata), 32'd0);
      exp_last_rdata = 8'h00;
      run_op(1'b0, 24'h35, 8'h00, 0, 1'b0, -1);

      // 16-bit build: byte pin and zero-extended commands
      check_eq("byte_dw16", 32'(byte16), 32'd1);
      check_eq("wp16_high", 32'(wp16), 32'd1);
      @(negedge clk);
      addr16 = 24'h35; data16 = 16'hA5C3; rw16 = 1'b1; fb16 = 1'b1;
      n16 = 0; dn = 0; cap16_n = 0; prev16 = 1'b1;
      while (n16 < 500) begin
         @(negedge clk);
         n16++;
         fb16 = 1'b0;
         if (we16 && !prev16) begin
            if (cap16_n < 3) cap16[cap16_n] = dout16;
            cap16_n++;
         end
         prev16 = we16;
         if (done16) begin
            dn = n16;
            break;
         end
      end
      check_eq("dw16_done_latency", 32'(dn), 32'(3 * (T_WP + 2) + 3 + 1));
      check_eq("dw16_write_cycles", 32'(cap16_n), 32'd3);
      check_eq("dw16_cmd_setup", 32'(cap16[0]), 32'h0040);
      check_eq("dw16_data", 32'(cap16[1]), 32'hA5C3);
      check_eq("dw16_cmd_readarray", 32'(cap16[2]), 32'h00FF);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
